// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, instruction memory write port and status for imem_loader
interface imem_loader_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [31:0]       dina;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_written;

  modport master (
    input  start, rx_valid, rx_data,
    output rx_ready, wea, addra, dina, busy, done, error, words_written
  );

  modport slave (
    output start, rx_valid, rx_data,
    input  rx_ready, wea, addra, dina, busy, done, error, words_written
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream to instruction memory word writes
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic          clka,
  input  logic          rsta,
  imem_loader_if.master bus
);

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CKSUM, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
`endif

  localparam logic [15:0] DEPTH_L = 16'(DEPTH);

  state_t      state;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  cksum;
`endif

  logic        xfer;
  logic [15:0] full_len;
  logic [15:0] ww_next;
  logic        last_word;

  assign xfer      = bus.rx_valid & bus.rx_ready;
  assign full_len  = {bus.rx_data, len[7:0]};
  assign ww_next   = 16'(bus.words_written) + 16'd1;
  assign last_word = (ww_next == len);

  always_ff @(posedge clka) begin
    if (rsta) begin
      state             <= IDLE;
      len               <= '0;
      byte_idx          <= '0;
      word_buf          <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum             <= '0;
`endif
      bus.rx_ready      <= 1'b0;
      bus.wea           <= 1'b0;
      bus.addra         <= '0;
      bus.dina          <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.error         <= 1'b0;
      bus.words_written <= '0;
    end else begin
      bus.wea <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            state             <= LEN_LO;
            byte_idx          <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum             <= '0;
`endif
            bus.rx_ready      <= 1'b1;
            bus.busy          <= 1'b1;
            bus.done          <= 1'b0;
            bus.error         <= 1'b0;
            bus.words_written <= '0;
          end else if (state == DONE) begin
            // Entry from DATA leaves done low for the cycle carrying the final write.
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end

        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.rx_data;
            state    <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= bus.rx_data;
            if (full_len == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state        <= CKSUM;
`else
              state        <= DONE;
              bus.rx_ready <= 1'b0;
              bus.done     <= 1'b1;
              bus.busy     <= 1'b0;
`endif
            end else if (full_len > DEPTH_L) begin
              state        <= ERROR;
              bus.rx_ready <= 1'b0;
              bus.error    <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= cksum ^ bus.rx_data;
`endif
            case (byte_idx)
              2'd0: word_buf[7:0]   <= bus.rx_data;
              2'd1: word_buf[15:8]  <= bus.rx_data;
              2'd2: word_buf[23:16] <= bus.rx_data;
              default: begin
                bus.wea           <= 1'b1;
                bus.addra         <= bus.words_written[ADDR_W-1:0];
                bus.dina          <= {bus.rx_data, word_buf};
                bus.words_written <= ww_next[ADDR_W:0];
                if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                  state        <= CKSUM;
`else
                  state        <= DONE;
                  bus.rx_ready <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM: begin
          if (xfer) begin
            bus.rx_ready <= 1'b0;
            bus.busy     <= 1'b0;
            if (bus.rx_data == cksum) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state     <= ERROR;
              bus.error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state        <= IDLE;
          bus.rx_ready <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 9;

  logic clka = 1'b0;
  logic rsta;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic              wr_busy[$];
  logic              wr_done[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(512)) dut (.clka(clka), .rsta(rsta), .bus(bus));

  always #5 clka = ~clka;

  always @(negedge clka) begin
    if (bus.wea) begin
      wr_addr.push_back(bus.addra);
      wr_data.push_back(bus.dina);
      wr_busy.push_back(bus.busy);
      wr_done.push_back(bus.done);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_busy.delete();
    wr_done.delete();
  endtask

  task automatic start_load();
    @(posedge clka);
    #1 bus.start = 1'b1;
    @(posedge clka);
    #1 bus.start = 1'b0;
    clear_log();
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clka);
      acc = bus.rx_ready;
      @(posedge clka);
    end
    #1;
    if (!acc) check("rx_ready_timeout", {31'd0, acc}, 32'd1);
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clka);
      #1;
    end
  endtask

  task automatic end_stream();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic wait_end(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clka);
      seen = bus.done | bus.error;
    end
    check({tag, "_end_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic send_t1(input int gap);
    logic [7:0] s [10];
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 10; i++) send_byte(s[i], gap);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h2A, gap);
`endif
    end_stream();
  endtask

  task automatic check_t1(input string tag);
    wait_end(tag);
    check({tag, "_nwr"}, wr_addr.size(), 32'd2);
    if (wr_addr.size() >= 2) begin
      check({tag, "_addr0"}, 32'(wr_addr[0]), 32'd0);
      check({tag, "_data0"}, wr_data[0], 32'h12345678);
      check({tag, "_addr1"}, 32'(wr_addr[1]), 32'd1);
      check({tag, "_data1"}, wr_data[1], 32'hDEADBEEF);
`ifndef IMEM_LOADER_CKSUM_EN
      check({tag, "_busy_at_last_wr"}, {31'd0, wr_busy[1]}, 32'd1);
      check({tag, "_done_at_last_wr"}, {31'd0, wr_done[1]}, 32'd0);
`endif
    end
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    check({tag, "_ww"}, 32'(bus.words_written), 32'd2);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clka);
    check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    check({tag, "_wea"}, {31'd0, bus.wea}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    check({tag, "_addra"}, 32'(bus.addra), 32'd0);
    check({tag, "_dina"}, bus.dina, 32'd0);
    check({tag, "_ww"}, 32'(bus.words_written), 32'd0);
  endtask

  initial begin
    int bad;
    rsta         = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clka);
    #1 rsta = 1'b0;
    check_reset("rst");

    // 1: two words back-to-back
    start_load();
    check("t1_busy_after_start", {31'd0, bus.busy}, 32'd1);
    check("t1_rx_ready_after_start", {31'd0, bus.rx_ready}, 32'd1);
    send_t1(0);
    check_t1("t1");

    // 2: same stream with a one-cycle gap between bytes
    start_load();
    check("t2_done_cleared", {31'd0, bus.done}, 32'd0);
    check("t2_ww_cleared", 32'(bus.words_written), 32'd0);
    send_t1(1);
    check_t1("t2");

    // 3: zero-length image
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h00, 0);
`endif
    end_stream();
    wait_end("t3");
    check("t3_done", {31'd0, bus.done}, 32'd1);
    check("t3_nwr", wr_addr.size(), 32'd0);
    check("t3_ww", 32'(bus.words_written), 32'd0);

    // 4: length 513 rejected, then a valid load recovers
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    end_stream();
    wait_end("t4");
    check("t4_error", {31'd0, bus.error}, 32'd1);
    check("t4_done", {31'd0, bus.done}, 32'd0);
    check("t4_busy", {31'd0, bus.busy}, 32'd0);
    check("t4_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("t4_nwr", wr_addr.size(), 32'd0);
    start_load();
    check("t4_error_cleared", {31'd0, bus.error}, 32'd0);
    send_t1(0);
    check_t1("t4b");

    // 5: full-depth image, word i holds i
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 512; i++) begin
      logic [15:0] v;
      v = 16'(i);
      send_byte(v[7:0], 0);
      send_byte(v[15:8], 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h00, 0);
`endif
    end_stream();
    wait_end("t5");
    check("t5_nwr", wr_addr.size(), 32'd512);
    bad = 0;
    foreach (wr_addr[k]) if (32'(wr_addr[k]) != 32'(k) || wr_data[k] != 32'(k)) bad++;
    check("t5_seq_bad", bad, 32'd0);
    if (wr_addr.size() == 512) begin
      check("t5_last_addr", 32'(wr_addr[511]), 32'h1FF);
      check("t5_last_data", wr_data[511], 32'd511);
    end
    check("t5_ww", 32'(bus.words_written), 32'd512);
    check("t5_done", {31'd0, bus.done}, 32'd1);

    // 6: reset mid-word, then a fresh load
    start_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    end_stream();
    rsta = 1'b1;
    @(posedge clka);
    #1 rsta = 1'b0;
    check("t6_nwr", wr_addr.size(), 32'd0);
    check_reset("t6_rst");

    // 6b: reset on the same edge as the word's last byte suppresses the write
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    bus.rx_data = 8'h44;
    rsta = 1'b1;
    @(posedge clka);
    #1 rsta = 1'b0;
    end_stream();
    repeat (2) @(negedge clka);
    check("t6b_nwr", wr_addr.size(), 32'd0);
    check_reset("t6b_rst");

    start_load();
    send_t1(0);
    check_t1("t6c");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
